// File: rtl/dmem_access_ctrl.sv
// Multi-cycle data-memory controller between a stallable CPU and a 1-cycle-latency block RAM.
// Define DMEM_ACCESS_CTRL_ERR_EN to trap accesses beyond the RAM instead of wrapping.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] LED_ADDR   = 32'h00002000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [31:0]           addr,
    input  logic [31:0]           write_data,
    input  logic [3:0]            sign_mask,
    output logic [31:0]           read_data,
    output logic                  clk_stall,
    output logic [7:0]            led,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [31:0]           ram_rdata,
    output logic                  err
);

    typedef enum logic [2:0] {StIdle, StRead, StLatch, StWrite, StDone} state_e;

    state_e                state;
    logic                  op_store_q;
    logic [1:0]            size_q;
    logic                  sext_q;
    logic [1:0]            lane_q;
    logic [15:0]           wdata_q;

    logic                  is_led;
    logic                  is_req;
    logic                  oor;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [31:0]           load_fmt;
    logic [31:0]           merged;
    logic                  unused_sign_mask;

    assign unused_sign_mask = sign_mask[3];

    assign is_led   = (addr == LED_ADDR);
    assign is_req   = memread | memwrite;
    assign word_idx = addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ACCESS_CTRL_ERR_EN
    assign oor = ((addr >> (ADDR_WIDTH + 2)) != 32'd0) && !is_led;
`else
    assign oor = 1'b0;
    assign err = 1'b0;
`endif

    // Lane extraction and sign/zero extension of the word returned by the RAM.
    always_comb begin
        lane_byte = ram_rdata[{lane_q, 3'b000} +: 8];
        lane_half = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_fmt  = ram_rdata;
        if (size_q == 2'b00) begin
            load_fmt = {{24{sext_q & lane_byte[7]}}, lane_byte};
        end else if (size_q == 2'b01) begin
            load_fmt = {{16{sext_q & lane_half[15]}}, lane_half};
        end
    end

    // Sub-word store data merged over the old RAM word; untouched lanes are kept.
    always_comb begin
        merged = ram_rdata;
        if (size_q == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            clk_stall  <= 1'b0;
            read_data  <= 32'd0;
            led        <= 8'd0;
            ram_addr   <= '0;
            ram_wdata  <= 32'd0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            op_store_q <= 1'b0;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 16'd0;
`ifdef DMEM_ACCESS_CTRL_ERR_EN
            err        <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (is_req) begin
                        op_store_q <= memwrite;
                        size_q     <= sign_mask[1:0];
                        sext_q     <= sign_mask[2];
                        lane_q     <= addr[1:0];
                        wdata_q    <= write_data[15:0];
                        if (is_led) begin
                            state <= StDone;
                            if (memwrite) begin
                                led <= write_data[7:0];
                            end else begin
                                read_data <= {24'd0, led};
                            end
                        end else if (oor) begin
                            state <= StDone;
                            if (!memwrite) begin
                                read_data <= 32'd0;
                            end
`ifdef DMEM_ACCESS_CTRL_ERR_EN
                            err <= 1'b1;
`endif
                        end else if (memwrite && sign_mask[1]) begin
                            state     <= StWrite;
                            ram_addr  <= word_idx;
                            ram_wdata <= write_data;
                            ram_we    <= 1'b1;
                            clk_stall <= 1'b1;
                        end else begin
                            // Loads and sub-word stores both start with a RAM read.
                            state     <= StRead;
                            ram_addr  <= word_idx;
                            ram_re    <= 1'b1;
                            clk_stall <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    state  <= StLatch;
                    ram_re <= 1'b0;
                end
                StLatch: begin
                    if (op_store_q) begin
                        state     <= StWrite;
                        ram_wdata <= merged;
                        ram_we    <= 1'b1;
                    end else begin
                        state     <= StDone;
                        read_data <= load_fmt;
                        clk_stall <= 1'b0;
                    end
                end
                StWrite: begin
                    state     <= StDone;
                    ram_we    <= 1'b0;
                    clk_stall <= 1'b0;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state     <= StIdle;
                    ram_we    <= 1'b0;
                    ram_re    <= 1'b0;
                    clk_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, reset-abort sequence, and random accesses
// checked against a byte-addressed memory model.
module tb_dmem_access_ctrl;

    localparam int unsigned ADDR_WIDTH = 10;
    localparam logic [31:0] LED_ADDR   = 32'h00002000;
`ifdef DMEM_ACCESS_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  memread;
    logic                  memwrite;
    logic [31:0]           addr;
    logic [31:0]           write_data;
    logic [3:0]            sign_mask;
    logic [31:0]           read_data;
    logic                  clk_stall;
    logic [7:0]            led;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic                  ram_we;
    logic                  ram_re;
    logic [31:0]           ram_rdata;
    logic                  err;

    dmem_access_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LED_ADDR   (LED_ADDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memread    (memread),
        .memwrite   (memwrite),
        .addr       (addr),
        .write_data (write_data),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .clk_stall  (clk_stall),
        .led        (led),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Block RAM with one cycle of read latency.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    int we_pulses = 0;
    int overlap   = 0;
    always @(negedge clk) begin
        if (ram_we) we_pulses <= we_pulses + 1;
        if (ram_we && ram_re) overlap <= overlap + 1;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  ref_bytes [4096];
    logic [7:0]  led_ref = 8'd0;
    logic [31:0] rd_ref  = 32'd0;
    logic        err_ref = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic model_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] sm, output int exp_stalls,
                                output int exp_wes);
        int n;
        int base;
        logic [31:0] v;
        exp_stalls = 0;
        exp_wes    = 0;
        n = sm[1] ? 4 : (sm[0] ? 2 : 1);
        if (a == LED_ADDR) begin
            if (wr) led_ref = wd[7:0];
            else rd_ref = {24'h0, led_ref};
        end else if (ERR_EN && (a >> 12) != 32'd0) begin
            if (!wr) rd_ref = 32'd0;
            err_ref = 1'b1;
        end else begin
            base = (int'(a[11:0]) / n) * n;
            if (wr) begin
                for (int i = 0; i < n; i++) ref_bytes[base + i] = wd[8*i +: 8];
                exp_stalls = (n == 4) ? 1 : 3;
                exp_wes    = 1;
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
                if (sm[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
                rd_ref     = v;
                exp_stalls = 2;
            end
        end
    endtask

    // Runs one access from IDLE back to IDLE; seq collects {ram_we, ram_re} per stalled cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] sm, output int stalls,
                             output logic [7:0] seq, output int wes);
        int we0;
        we0        = we_pulses;
        memread    = rd;
        memwrite   = wr;
        addr       = a;
        write_data = wd;
        sign_mask  = sm;
        stalls     = 0;
        seq        = 8'd0;
        do begin
            @(posedge clk);
            #1;
            if (clk_stall) begin
                stalls++;
                seq = {seq[5:0], ram_we, ram_re};
            end
        end while (clk_stall && stalls < 8);
        checks++;
        if (clk_stall) begin
            errors++;
            $display("FAIL access_timeout: got stall after %0d cycles want done", stalls);
        end
        memread  = 1'b0;
        memwrite = 1'b0;
        @(posedge clk);
        #1;
        wes = we_pulses - we0;
    endtask

    task automatic rand_access(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] sm, input string tag);
        int es, ew, st, wes;
        logic [7:0] seq;
        model_access(wr, a, wd, sm, es, ew);
        do_access(rd, wr, a, wd, sm, st, seq, wes);
        check32({tag, "_stalls"}, st, es);
        check32({tag, "_we_pulses"}, wes, ew);
        check32({tag, "_rdata"}, read_data, rd_ref);
        check32({tag, "_led"}, {24'd0, led}, {24'd0, led_ref});
        check32({tag, "_err"}, {31'd0, err}, {31'd0, err_ref});
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  sm;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_led;
        int          exp_stalls;
        logic [7:0]  exp_seq;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, es, ew, wes, we0;
        logic [7:0] seq;
        logic [31:0] ra, rwd;
        logic [3:0] rsm;
        int op;

        // seq codes: word store 8'h02, load 8'h04 (READ, LATCH), RMW 8'h12 (READ, LATCH, WRITE)
        vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 4'h2, 32'h00000000, 8'h00, 1, 8'h02};
        vecs[1]  = '{1'b1, 1'b0, 32'h13,   32'h0,        4'h4, 32'hFFFFFFDE, 8'h00, 2, 8'h04};
        vecs[2]  = '{1'b0, 1'b1, 32'h20,   32'h11223344, 4'h2, 32'hFFFFFFDE, 8'h00, 1, 8'h02};
        vecs[3]  = '{1'b0, 1'b1, 32'h22,   32'h1234ABCD, 4'h1, 32'hFFFFFFDE, 8'h00, 3, 8'h12};
        vecs[4]  = '{1'b1, 1'b0, 32'h20,   32'h0,        4'h2, 32'hABCD3344, 8'h00, 2, 8'h04};
        vecs[5]  = '{1'b1, 1'b0, 32'h22,   32'h0,        4'h1, 32'h0000ABCD, 8'h00, 2, 8'h04};
        vecs[6]  = '{1'b1, 1'b0, 32'h22,   32'h0,        4'h5, 32'hFFFFABCD, 8'h00, 2, 8'h04};
        vecs[7]  = '{1'b0, 1'b1, LED_ADDR, 32'h0000005A, 4'h2, 32'hFFFFABCD, 8'h5A, 0, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, LED_ADDR, 32'h0,        4'h2, 32'h0000005A, 8'h5A, 0, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 32'h23,   32'h0,        4'h1, 32'h0000ABCD, 8'h5A, 2, 8'h04};
        vecs[10] = '{1'b1, 1'b0, 32'h13,   32'h0,        4'h2, 32'hDEADBEEF, 8'h5A, 2, 8'h04};
        vecs[11] = '{1'b0, 1'b1, 32'h11,   32'hFFFFFF77, 4'h0, 32'hDEADBEEF, 8'h5A, 3, 8'h12};
        vecs[12] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h2, 32'hDEAD77EF, 8'h5A, 2, 8'h04};
        vecs[13] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h8, 32'h000000EF, 8'h5A, 2, 8'h04};
        vecs[14] = '{1'b1, 1'b0, 32'h11,   32'h0,        4'h4, 32'h00000077, 8'h5A, 2, 8'h04};
        vecs[15] = '{1'b1, 1'b1, 32'h30,   32'hCAFEF00D, 4'h2, 32'h00000077, 8'h5A, 1, 8'h02};
        vecs[16] = '{1'b1, 1'b0, 32'h30,   32'h0,        4'h2, 32'hCAFEF00D, 8'h5A, 2, 8'h04};

        reset      = 1'b1;
        memread    = 1'b0;
        memwrite   = 1'b0;
        addr       = 32'd0;
        write_data = 32'd0;
        sign_mask  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_stall", {31'd0, clk_stall}, 32'd0);
        check32("reset_rdata", read_data, 32'd0);
        check32("reset_led", {24'd0, led}, 32'd0);
        check32("reset_ram_ctl", {30'd0, ram_we, ram_re}, 32'd0);
        check32("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            model_access(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].sm, es, ew);
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].sm, st, seq, wes);
            check32($sformatf("vec%0d_stalls", i), st, vecs[i].exp_stalls);
            check32($sformatf("vec%0d_seq", i), {24'd0, seq}, {24'd0, vecs[i].exp_seq});
            check32($sformatf("vec%0d_rdata", i), read_data, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vecs[i].exp_led});
            if (vecs[i].a == LED_ADDR) check32($sformatf("vec%0d_led_we", i), wes, 0);
        end

        // Upper address bits: trap with the error feature, wrap to word 0 without it.
        model_access(1'b1, 32'h0, 32'h600DF00D, 4'h2, es, ew);
        do_access(1'b0, 1'b1, 32'h0, 32'h600DF00D, 4'h2, st, seq, wes);
        model_access(1'b0, 32'h00100000, 32'h0, 4'h2, es, ew);
        do_access(1'b1, 1'b0, 32'h00100000, 32'h0, 4'h2, st, seq, wes);
        check32("oor_rdata", read_data, ERR_EN ? 32'h0 : 32'h600DF00D);
        check32("oor_err", {31'd0, err}, {31'd0, ERR_EN});
        check32("oor_stalls", st, ERR_EN ? 0 : 2);
        repeat (2) @(posedge clk);
        #1;
        check32("oor_err_sticky", {31'd0, err}, {31'd0, ERR_EN});

        // Reset in LATCH of a byte store aborts it without touching the RAM.
        model_access(1'b1, 32'h40, 32'h01020304, 4'h2, es, ew);
        do_access(1'b0, 1'b1, 32'h40, 32'h01020304, 4'h2, st, seq, wes);
        memwrite   = 1'b1;
        addr       = 32'h41;
        write_data = 32'h000000EE;
        sign_mask  = 4'h0;
        @(posedge clk);
        #1;
        check32("rmw_read_re", {31'd0, ram_re}, 32'd1);
        @(posedge clk);
        #1;
        check32("rmw_latch_ctl", {29'd0, clk_stall, ram_we, ram_re}, 32'h4);
        we0   = we_pulses;
        reset = 1'b1;
        #1;
        check32("abort_stall", {31'd0, clk_stall}, 32'd0);
        check32("abort_rdata", read_data, 32'd0);
        check32("abort_led", {24'd0, led}, 32'd0);
        check32("abort_ram_ctl", {30'd0, ram_we, ram_re}, 32'd0);
        check32("abort_ram_addr", {22'd0, ram_addr}, 32'd0);
        check32("abort_ram_wdata", ram_wdata, 32'd0);
        check32("abort_err", {31'd0, err}, 32'd0);
        memwrite = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check32("abort_no_we", we_pulses - we0, 0);
        led_ref = 8'd0;
        rd_ref  = 32'd0;
        err_ref = 1'b0;
        rand_access(1'b1, 1'b0, 32'h40, 32'h0, 4'h2, "abort_word_kept");
        check32("abort_word_value", read_data, 32'h01020304);

        // Preload the random window (bytes 0x100..0x13F) so the model and RAM agree.
        for (int w = 0; w < 16; w++) begin
            model_access(1'b1, 32'h100 + 32'(4 * w), $urandom, 4'h2, es, ew);
            do_access(1'b0, 1'b1, 32'h100 + 32'(4 * w), {ref_bytes[259 + 4*w],
                      ref_bytes[258 + 4*w], ref_bytes[257 + 4*w], ref_bytes[256 + 4*w]},
                      4'h2, st, seq, wes);
        end

        for (int k = 0; k < 200; k++) begin
            op  = $urandom_range(0, 2);
            rsm = 4'($urandom_range(0, 15));
            rwd = $urandom;
            ra  = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) ra = ra | ($urandom & 32'hFFFFF000);
            if ($urandom_range(0, 9) == 0) ra = LED_ADDR;
            rand_access(op != 1, op != 0, ra, rwd, rsm, $sformatf("rnd%0d", k));
        end

        check32("we_re_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of the attached block RAM (1024 x 32).
REQ-002 SHALL have parameter LED_ADDR, default 32'h00002000, byte address of the memory-mapped LED register.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports memread, input, 1 and memwrite, input, 1, the CPU access requests.
REQ-006 SHALL have port addr, input, 32, the CPU byte address.
REQ-007 SHALL have port write_data, input, 32, the CPU store data, right-aligned.
REQ-008 SHALL have port sign_mask, input, 4: [1:0] size (00 byte, 01 half, 1x word); [2] sign-extend on read; [3] ignored.
REQ-009 SHALL have port read_data, output, 32, the formatted load result.
REQ-010 SHALL have port clk_stall, output, 1, registered; high holds the CPU clock.
REQ-011 SHALL have port led, output, 8, the LED register.
REQ-012 SHALL have ports ram_addr (output, ADDR_WIDTH), ram_wdata (output, 32), ram_we (output, 1), ram_re (output, 1) and ram_rdata (input, 32); the RAM returns data one cycle after ram_re.
REQ-013 SHALL have port err, output, 1, sticky out-of-range flag (see Configuration).

Function
REQ-014 SHALL implement states IDLE, READ, LATCH, WRITE, DONE.
REQ-015 SHALL have clk_stall = 1 in READ, LATCH and WRITE, and 0 in IDLE and DONE.
REQ-016 SHALL sample requests only in IDLE; DONE always goes to IDLE after one cycle, so the CPU gets exactly one clock edge per access.
REQ-017 In IDLE, a load (memread=1, memwrite=0) SHALL go to READ; the load path is READ (ram_re=1, ram_addr=addr[ADDR_WIDTH+1:2]) -> LATCH -> DONE.
REQ-018 In LATCH of a load, read_data SHALL be registered: byte lane addr[1:0] or half lane addr[1] is extracted, then sign- or zero-extended per sign_mask[2]; a word load passes through unchanged.
REQ-019 A word store SHALL go IDLE -> WRITE (ram_we=1, ram_wdata=write_data) -> DONE.
REQ-020 A byte or half store SHALL read-modify-write: READ -> LATCH (merge the write_data low byte/half into the selected lane, other lanes kept) -> WRITE -> DONE.
REQ-021 Half accesses SHALL ignore addr[0]; word accesses SHALL ignore addr[1:0].
REQ-022 memread and memwrite both high SHALL be treated as a store.
REQ-023 A store with addr == LED_ADDR SHALL go IDLE -> DONE, set led <= write_data[7:0], and SHALL NOT access the RAM.
REQ-024 A load with addr == LED_ADDR SHALL go IDLE -> DONE with read_data = {24'b0, led}.
REQ-025 ram_we and ram_re SHALL never be high in the same cycle; both SHALL be 0 outside WRITE and READ respectively.
REQ-026 read_data SHALL hold its value until the next load completes.

Reset
REQ-027 Reset SHALL force state IDLE, clk_stall=0, read_data=0, led=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0 and err=0, immediately and independent of clk.
REQ-028 Reset asserted mid-access SHALL abort the access; a partially started read-modify-write SHALL NOT write the RAM.

Configuration
REQ-029 With macro DMEM_ACCESS_CTRL_ERR_EN defined, an access whose addr[31:ADDR_WIDTH+2] is nonzero and is not LED_ADDR SHALL go IDLE -> DONE without RAM access, return read_data=0 for loads, and set err until reset.
REQ-030 Without DMEM_ACCESS_CTRL_ERR_EN, upper address bits SHALL be ignored (address wraps modulo RAM size) and err SHALL be tied 0.

Verification
REQ-031 Word store 0xDEADBEEF to 0x10, then signed byte load at 0x13 -> clk_stall high 1 cycle for the store and 2 for the load; read_data = 0xFFFFFFDE.
REQ-032 Word 0x11223344 at 0x20, then half store 0xABCD to 0x22 -> RAM word 0x20 = 0xABCD3344; the RMW sequence is READ, LATCH, WRITE.
REQ-033 Unsigned half load at 0x22 after REQ-032 -> read_data = 0x0000ABCD; with sign_mask[2]=1 -> 0xFFFFABCD.
REQ-034 Store 0x5A to LED_ADDR -> led = 0x5A next cycle, no ram_we, clk_stall never asserted; a load from LED_ADDR returns 0x0000005A.
REQ-035 Reset asserted during LATCH of a byte store -> IDLE immediately, ram_we never pulses, target RAM word unchanged, all outputs at reset values.
REQ-036 With DMEM_ACCESS_CTRL_ERR_EN, load from 0x00100000 -> read_data = 0 and err = 1 until reset; without the macro, RAM word 0 is read and err stays 0.
